m_dram_responder: RTL and testbench
===================================

# m_dram_responder

Responder end of the core's DRAM request interface: it accepts the load and store requests a CPU/MMU block issues on the `w_dram_*` bus and serves them from an internal word-organized RAM after a fixed, configurable latency. It handles byte, halfword and word sizes with sign or zero extension, and produces `w_init_done` for the core reset gate. It is used as the simulation and FPGA-BRAM memory model behind one hart.

## Interface
- ADDR_W, 14: word-address width; RAM holds 2^ADDR_W 32-bit words; byte space is 2^(ADDR_W+2).
- LATENCY, 2: busy cycles per request; legal range 1..15.

- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- w_dram_addr  in  32  byte address of the request.
- w_dram_wdata  in  32  store data, right-aligned (bits [7:0] for a byte, [15:0] for a half).
- w_dram_we_t  in  1  store request strobe, one cycle.
- w_dram_le  in  1  load request strobe, one cycle.
- w_dram_ctrl  in  3  size/sign code: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3, 6 and 7 behave as LW.
- w_dram_odata  out  32  load result, extended per ctrl.
- w_dram_busy  out  1  registered busy flag; high while a request or scrub is in progress.
- w_init_done  out  1  high once the memory is usable.
- w_rsp_err  out  1  sticky out-of-range flag; cleared only by RST.

## Operation
- States: SCRUB, IDLE, BUSY.
- Acceptance: a request is accepted at a posedge when state is IDLE and `w_dram_le | w_dram_we_t` is 1. The block latches addr, wdata, ctrl and the request type.
- If `w_dram_le` and `w_dram_we_t` are both high, the request is a store and `odata` is not updated.
- Strobes seen in SCRUB or BUSY are ignored and are not queued.
- Word index is addr[ADDR_W+1:2].
- Alignment is not checked. The low address bits are masked to the access size:
  - half uses addr[1];
  - word ignores addr[1:0].
- Out of range means addr[31:ADDR_W+2] is nonzero. On such a request:
  - a store is dropped;
  - a load returns 0;
  - `w_rsp_err` is set;
  - the full LATENCY is still consumed.
- Store: ctrl[1:0] selects the width; 0 is a byte, 1 is a half, any other value is a word.
  - The data is replicated into the addressed lane(s) with byte enables.
  - Other bytes of the word are preserved.
  - The write commits in the last BUSY cycle.
- Load: the addressed byte or half is shifted down, then sign-extended for ctrl 0/1 or zero-extended for ctrl 4/5.
  - `odata` is loaded in the last BUSY cycle and then holds until the next load completes.
- Transitions:
  - IDLE → BUSY on acceptance; counter = LATENCY.
  - BUSY decrements the counter each cycle; at counter == 1 it commits and returns to IDLE.
- Reset mid-request: the request is cancelled and an uncommitted store never writes. RAM contents survive reset, except when cleared by the scrub.

## Timing
- Reset values:
  - busy = 0;
  - odata = 0;
  - w_rsp_err = 0;
  - w_init_done = 0 (with scrub) or 1 (without scrub), in the first cycle after RST falls;
  - state = SCRUB (with scrub) or IDLE (without scrub).
- Request in cycle T: busy is high in cycles T+1 .. T+LATENCY and low at T+LATENCY+1. Load data is valid from T+LATENCY+1.
- `busy` does not rise in the request cycle itself. The initiator must drop its strobe after one cycle and wait for `busy` to rise and then fall.
- Back-to-back throughput: one request per LATENCY+1 cycles.
- A store followed by a load to the same address returns the new data.

## Configuration
- `DRAM_RSP_SCRUB_EN` defined:
  - After reset, state SCRUB writes 0 to word 0, 1, …, 2^ADDR_W−1, one word per cycle.
  - During SCRUB, busy = 1 and init_done = 0.
  - After the last word, busy drops and init_done rises; this is 2^ADDR_W+1 cycles after RST deasserts.
  - RST during SCRUB restarts the scrub from word 0.
- Not defined: no scrub, RAM contents are undefined, and init_done = 1 from the first cycle after reset.

## Test plan
- SW 0xDEADBEEF to 0x100 (ctrl 2), then LW 0x100 → odata 0xDEADBEEF. Busy is high exactly LATENCY cycles for each request.
- After the word above:
  - SB 0x7F to 0x101 → LW 0x100 returns 0xDEAD7FEF;
  - LB 0x103 → 0xFFFFFFDE;
  - LBU 0x103 → 0x000000DE;
  - LH 0x102 → 0xFFFFDEAD.
- `le` and `we_t` both high with wdata 0x12345678 to 0x200 → the word is stored and odata keeps its previous value. A strobe asserted while busy → ignored; memory and odata unchanged.
- LW from 1 << (ADDR_W+2) → odata 0, w_rsp_err 1 and stays 1. A store to the same address leaves word 0 unchanged.
- Raise RST in the first BUSY cycle of SW 0xCAFEF00D to 0x40 that overwrites 0x11111111 → busy 0 next cycle; a later LW 0x40 returns 0x11111111.
- With `DRAM_RSP_SCRUB_EN` and ADDR_W = 4:
  - init_done rises 17 cycles after reset;
  - strobes during scrub are ignored;
  - LW of any word afterwards returns 0.

Source files
------------

// File: rtl/m_dram_responder.sv
// m_dram_responder: fixed-latency DRAM responder over a word-organized RAM.
// Optional power-up zero scrub enabled by defining DRAM_RSP_SCRUB_EN.
module m_dram_responder #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_init_done,
  output logic        w_rsp_err
);

  typedef enum logic [1:0] {
    SCRUB,
    IDLE,
    BUSY
  } state_t;

`ifdef DRAM_RSP_SCRUB_EN
  localparam state_t RST_STATE = SCRUB;
  localparam logic   RST_INIT  = 1'b0;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_INIT  = 1'b1;
`endif

  localparam logic [ADDR_W:0] SCRUB_ONE  = 1;
  localparam logic [ADDR_W:0] SCRUB_LAST = 1 << ADDR_W;

  state_t state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W:0]   scrub_idx;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ctrl_q;
  logic              store_q;

  logic              accept;
  logic              commit;
  logic              oor;
  logic              is_byte;
  logic              is_half;
  logic              sgn;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       word;
  logic [31:0]       sh;
  logic [15:0]       hw;
  logic [31:0]       ld_val;
  logic [31:0]       st_word;
  logic [3:0]        be;

  logic [31:0] mem [2**ADDR_W];

  assign accept  = (state == IDLE) && (w_dram_le | w_dram_we_t);
  assign commit  = (state == BUSY) && (cnt == 4'd1);
  assign widx    = addr_q[ADDR_W+1:2];
  assign oor     = |addr_q[31:ADDR_W+2];
  assign is_byte = (ctrl_q[1:0] == 2'd0);
  assign is_half = (ctrl_q[1:0] == 2'd1);
  assign sgn     = ~ctrl_q[2];
  assign word    = mem[widx];

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      SCRUB: if (scrub_idx == SCRUB_LAST) state_nxt = IDLE;
      IDLE:  if (accept) state_nxt = BUSY;
      BUSY:  if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, latency counter and scrub pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RST_STATE;
      cnt       <= '0;
      scrub_idx <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(LATENCY);
      else if (state == BUSY)
        cnt <= cnt - 4'd1;
      if (state == SCRUB)
        scrub_idx <= scrub_idx + SCRUB_ONE;
    end
  end

  // capture the accepted request
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= w_dram_addr;
      wdata_q <= w_dram_wdata;
      ctrl_q  <= w_dram_ctrl;
      store_q <= w_dram_we_t;
    end
  end

  // store lane replication and byte enables
  always_comb begin
    st_word = wdata_q;
    be      = 4'b1111;
    unique case (1'b1)
      is_byte: begin
        st_word = {4{wdata_q[7:0]}};
        be      = 4'b0001 << addr_q[1:0];
      end
      is_half: begin
        st_word = {2{wdata_q[15:0]}};
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_word = wdata_q;
        be      = 4'b1111;
      end
    endcase
  end

  // load lane extraction and extension
  always_comb begin
    sh     = word >> {addr_q[1:0], 3'b000};
    hw     = addr_q[1] ? word[31:16] : word[15:0];
    ld_val = word;
    unique case (1'b1)
      is_byte: ld_val = {{24{sgn & sh[7]}}, sh[7:0]};
      is_half: ld_val = {{16{sgn & hw[15]}}, hw};
      default: ld_val = word;
    endcase
    if (oor) ld_val = '0;
  end

  // RAM writes: scrub zeroing or committed store
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == SCRUB) begin
        if (!scrub_idx[ADDR_W])
          mem[scrub_idx[ADDR_W-1:0]] <= '0;
      end else if (commit && store_q && !oor) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[widx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  // registered status and load result
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_dram_busy  <= 1'b0;
      w_init_done  <= RST_INIT;
      w_rsp_err    <= 1'b0;
      w_dram_odata <= '0;
    end else begin
      w_dram_busy <= (state_nxt != IDLE);
      w_init_done <= (state_nxt != SCRUB);
      if (commit && oor)
        w_rsp_err <= 1'b1;
      if (commit && !store_q)
        w_dram_odata <= ld_val;
    end
  end

endmodule

// File: tb/tb_m_dram_responder.sv
// tb_m_dram_responder: scoreboard bench for m_dram_responder.
// Scrub scenarios run when DRAM_RSP_SCRUB_EN is defined.
module tb_m_dram_responder;

`ifdef DRAM_RSP_SCRUB_EN
  localparam int AW = 4;
`else
  localparam int AW = 14;
`endif
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we_t = 1'b0;
  logic        le = 1'b0;
  logic [2:0]  ctrl = '0;
  logic [31:0] odata;
  logic        busy;
  logic        init_done;
  logic        rsp_err;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] sb_q[$];

  m_dram_responder #(
    .ADDR_W (AW),
    .LATENCY(LAT)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .w_dram_addr (addr),
    .w_dram_wdata(wdata),
    .w_dram_we_t (we_t),
    .w_dram_le   (le),
    .w_dram_ctrl (ctrl),
    .w_dram_odata(odata),
    .w_dram_busy (busy),
    .w_init_done (init_done),
    .w_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one request; expected odata queued at drive time
  task automatic req(input string tag,
                     input logic l,
                     input logic w,
                     input logic [2:0] c,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] exp,
                     input bit poke);
    int n;
    logic [31:0] e;
    sb_q.push_back(exp);
    le = l; we_t = w; ctrl = c; addr = a; wdata = d;
    tick();
    le = 1'b0;
    we_t = poke;
    if (poke) begin
      addr = 32'h100; wdata = 32'h0; ctrl = 3'd2;
    end
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
      we_t = 1'b0;
    end
    we_t = 1'b0;
    check({tag, "_busy"}, 32'(n), 32'(LAT));
    e = sb_q.pop_front();
    check({tag, "_odata"}, odata, e);
  endtask

`ifdef DRAM_RSP_SCRUB_EN
  task automatic scrub_reset(input string tag);
    int k;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check({tag, "_init_low"}, 32'(init_done), 32'd0);
    for (k = 1; k < 60; k++) begin
      tick();
      if (k == 5) check({tag, "_scrub_busy"}, 32'(busy), 32'd1);
      if (k <= 3) begin
        we_t = 1'b1; ctrl = 3'd2;
        addr = 32'h4; wdata = 32'hFFFF_FFFF;
      end else begin
        we_t = 1'b0;
      end
      if (init_done) break;
    end
    we_t = 1'b0;
    check({tag, "_init_lat"}, 32'(k), 32'd17);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask
`endif

  initial begin
`ifdef DRAM_RSP_SCRUB_EN
    scrub_reset("s1");
    check("s1_odata", odata, 32'h0);
    for (int i = 0; i < 16; i++)
      req("fill", 1'b0, 1'b1, 3'd2, 32'(i * 4), 32'hFFFF_FFFF, 32'h0, 1'b0);
    req("lw_fill", 1'b1, 1'b0, 3'd2, 32'h4, 32'h0, 32'hFFFF_FFFF, 1'b0);
    scrub_reset("s2");
    for (int i = 0; i < 16; i++)
      req("lw_zero", 1'b1, 1'b0, 3'd2, 32'(i * 4), 32'h0, 32'h0, 1'b0);
`else
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_odata", odata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    check("rst_init", 32'(init_done), 32'd1);
    tick();
    check("init_after", 32'(init_done), 32'd1);
    check("busy_after", 32'(busy), 32'd0);

    req("sw", 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req("lw", 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req("sb", 1'b0, 1'b1, 3'd0, 32'h101, 32'hAAAA_AA7F, 32'hDEAD_BEEF, 1'b0);
    req("lw2", 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_7FEF, 1'b0);
    req("lb", 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'hFFFF_FFDE, 1'b0);
    req("lbu", 1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h0000_00DE, 1'b0);
    req("lh", 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'hFFFF_DEAD, 1'b0);
    req("lhu", 1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h0000_DEAD, 1'b0);
    req("lb_pos", 1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 32'h0000_007F, 1'b0);
    req("sh", 1'b0, 1'b1, 3'd1, 32'h102, 32'h5555_1234, 32'h0000_007F, 1'b0);
    req("lw_c7", 1'b1, 1'b0, 3'd7, 32'h103, 32'h0, 32'h1234_7FEF, 1'b0);
    req("both", 1'b1, 1'b1, 3'd2, 32'h200, 32'h1234_5678, 32'h1234_7FEF, 1'b0);
    req("lw200", 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h1234_5678, 1'b0);
    req("poke", 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h1234_7FEF, 1'b1);
    req("lw_c3", 1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h1234_7FEF, 1'b0);
    check("err_clear", 32'(rsp_err), 32'd0);

    req("sw0", 1'b0, 1'b1, 3'd2, 32'h0, 32'hA5A5_A5A5, 32'h1234_7FEF, 1'b0);
    req("lw_oor", 1'b1, 1'b0, 3'd2, 32'h1 << (AW + 2), 32'h0, 32'h0, 1'b0);
    check("err_set", 32'(rsp_err), 32'd1);
    req("sw_oor", 1'b0, 1'b1, 3'd2, 32'h1 << (AW + 2), 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("err_hold", 32'(rsp_err), 32'd1);
    req("lw0", 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0);
    check("err_sticky", 32'(rsp_err), 32'd1);

    req("sw40", 1'b0, 1'b1, 3'd2, 32'h40, 32'h1111_1111, 32'hA5A5_A5A5, 1'b0);
    we_t = 1'b1; ctrl = 3'd2; addr = 32'h40; wdata = 32'hCAFE_F00D;
    tick();
    we_t = 1'b0;
    check("cancel_busy_up", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("cancel_busy_down", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("cancel_err", 32'(rsp_err), 32'd0);
    check("cancel_odata", odata, 32'h0);
    req("lw40", 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h1111_1111, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
